// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - FIFO of (vector, hold) pairs played out on vec_out, each held 1+hold cycles
module vector_sequencer #(
  parameter int              BSIZE     = 3,
  parameter int              DEPTH     = 4,
  parameter int              HOLD_W    = 4,
  parameter logic [BSIZE-1:0] RESET_VEC = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [BSIZE-1:0]         ld_vec,
  input  logic [HOLD_W-1:0]        ld_hold,
  output logic [BSIZE-1:0]         vec_out,
  output logic                     vec_strobe,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BSIZE-1:0]    vec_mem [DEPTH];
  logic [HOLD_W-1:0]   hold_mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [BSIZE-1:0]    vec_q, vec_d;
  logic                strobe_q;
  logic                push, load, fifo_nonempty;

  // ld_ready comes only from the registered count, so a full FIFO never bypasses a pop
  assign ld_ready      = (count_q != CW'(DEPTH));
  assign push          = ld_valid && ld_ready;
  assign fifo_nonempty = (count_q != '0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (fifo_nonempty) load = 1'b1;
          else               state_d = S_DONE;
        end
      end
      S_APPLY: begin
        if (hold_q == '0) begin
          if (fifo_nonempty) load = 1'b1;
          else               state_d = S_DONE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_W'(1)) begin
          if (fifo_nonempty) load = 1'b1;
          else               state_d = S_DONE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d = S_APPLY;
      hold_d  = hold_mem[rd_ptr_q];
    end
  end

  always_comb begin
    vec_d = load ? vec_mem[rd_ptr_q] : vec_q;
    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      vec_mem[wr_ptr_q]  <= ld_vec;
      hold_mem[wr_ptr_q] <= ld_hold;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      vec_q    <= RESET_VEC;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      vec_q    <= vec_d;
      strobe_q <= load;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign vec_out    = vec_q;
  assign vec_strobe = strobe_q;
  assign busy       = (state_q == S_APPLY) || (state_q == S_HOLD);
  assign done       = (state_q == S_DONE);
  assign count      = count_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// tb/tb_vector_sequencer.sv - directed self-checking bench for vector_sequencer
module tb_vector_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic [2:0] ld_vec = '0;
  logic [3:0] ld_hold = '0;
  logic [2:0] vec_out;
  logic       vec_strobe;
  logic       busy;
  logic       done;
  logic [2:0] count;

  int tests_run = 0;
  int tests_failed = 0;

  vector_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_vec     (ld_vec),
    .ld_hold    (ld_hold),
    .vec_out    (vec_out),
    .vec_strobe (vec_strobe),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [2:0] v, input logic [3:0] h);
    ld_valid = 1'b1;
    ld_vec   = v;
    ld_hold  = h;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (vec_out !== 3'b000) begin tests_failed++; $display("FAIL reset_vec_out: got %b expected 000", vec_out); end
    tests_run++;
    if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests_run++;
    if ({ld_ready, busy, done, vec_strobe} !== 4'b1000) begin
      tests_failed++; $display("FAIL reset_flags: got rdy/busy/done/stb=%b expected 1000", {ld_ready, busy, done, vec_strobe});
    end
  endtask

  task automatic test_async_reset();
    load(3'b010, 4'd5);
    load(3'b011, 4'd0);
    pulse_start();
    tick();
    tick();
    tests_run++;
    if (!(busy === 1'b1 && vec_out === 3'b010 && count === 3'd1)) begin
      tests_failed++; $display("FAIL async_pre_hold: got busy=%b vec=%b count=%0d expected busy=1 vec=010 count=1", busy, vec_out, count);
    end
    #3;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (!(vec_out === 3'b000 && count === 3'd0 && ld_ready === 1'b1 && busy === 1'b0 && done === 1'b0)) begin
      tests_failed++;
      $display("FAIL async_reset: got vec=%b count=%0d rdy=%b busy=%b done=%b expected 000 0 1 0 0", vec_out, count, ld_ready, busy, done);
    end
    #1;
    reset_n = 1'b1;
    tick();
    load(3'b101, 4'd1);
    tests_run++;
    if (count !== 3'd1) begin tests_failed++; $display("FAIL async_reload_count: got %0d expected 1", count); end
    pulse_start();
    tests_run++;
    if (!(vec_out === 3'b101 && vec_strobe === 1'b1 && busy === 1'b1)) begin
      tests_failed++; $display("FAIL async_play_c0: got vec=%b stb=%b busy=%b expected 101 1 1", vec_out, vec_strobe, busy);
    end
    tick();
    tests_run++;
    if (!(vec_out === 3'b101 && vec_strobe === 1'b0 && busy === 1'b1)) begin
      tests_failed++; $display("FAIL async_play_c1: got vec=%b stb=%b busy=%b expected 101 0 1", vec_out, vec_strobe, busy);
    end
    tick();
    tests_run++;
    if (!(done === 1'b1 && busy === 1'b0 && vec_out === 3'b101)) begin
      tests_failed++; $display("FAIL async_play_done: got done=%b busy=%b vec=%b expected 1 0 101", done, busy, vec_out);
    end
  endtask

  task automatic test_sequence();
    logic [2:0] vecs [3];
    logic [3:0] holds [3];
    logic [2:0] exp_v [$];
    logic       exp_s [$];
    logic [1:0] exp_a [3];
    int         nstb;
    vecs[0] = 3'b000; holds[0] = 4'd0;
    vecs[1] = 3'b001; holds[1] = 4'd4;
    vecs[2] = 3'b100; holds[2] = 4'd4;
    exp_a[0] = 2'b00; exp_a[1] = 2'b00; exp_a[2] = 2'b10;
    for (int e = 0; e < 3; e++) begin
      load(vecs[e], holds[e]);
      for (int j = 0; j <= int'(holds[e]); j++) begin
        exp_v.push_back(vecs[e]);
        exp_s.push_back(j == 0);
      end
    end
    tests_run++;
    if (count !== 3'd3) begin tests_failed++; $display("FAIL seq_count_loaded: got %0d expected 3", count); end
    pulse_start();
    nstb = 0;
    for (int k = 0; k < exp_v.size(); k++) begin
      tests_run++;
      if (vec_out !== exp_v[k] || vec_strobe !== exp_s[k] || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL seq_cycle%0d: got vec=%b stb=%b busy=%b expected vec=%b stb=%b busy=1", k, vec_out, vec_strobe, busy, exp_v[k], exp_s[k]);
      end
      if (vec_strobe === 1'b1) begin
        if (nstb < 3) begin
          tests_run++;
          if (vec_out[2:1] !== exp_a[nstb]) begin
            tests_failed++; $display("FAIL seq_consumer_a%0d: got %b expected %b", nstb, vec_out[2:1], exp_a[nstb]);
          end
        end
        nstb++;
      end
      tick();
    end
    tests_run++;
    if (nstb !== 3) begin tests_failed++; $display("FAIL seq_strobe_count: got %0d expected 3", nstb); end
    tests_run++;
    if (!(done === 1'b1 && busy === 1'b0 && vec_out === 3'b100 && vec_strobe === 1'b0)) begin
      tests_failed++; $display("FAIL seq_done: got done=%b busy=%b vec=%b stb=%b expected 1 0 100 0", done, busy, vec_out, vec_strobe);
    end
  endtask

  task automatic test_full();
    logic [2:0] exp_order [5];
    logic [2:0] got [$];
    bool_done_wait: begin end
    exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b011;
    exp_order[3] = 3'b100; exp_order[4] = 3'b110;
    ld_valid = 1'b1;
    ld_hold  = 4'd2;
    for (int i = 1; i <= 4; i++) begin
      ld_vec = 3'(i);
      tick();
      if (i == 3) begin
        tests_run++;
        if (!(count === 3'd3 && ld_ready === 1'b1)) begin
          tests_failed++; $display("FAIL full_three: got count=%0d rdy=%b expected 3 1", count, ld_ready);
        end
      end
    end
    tests_run++;
    if (!(count === 3'd4 && ld_ready === 1'b0)) begin
      tests_failed++; $display("FAIL full_four: got count=%0d rdy=%b expected 4 0", count, ld_ready);
    end
    ld_vec = 3'b110;
    tick();
    tests_run++;
    if (!(count === 3'd4 && ld_ready === 1'b0)) begin
      tests_failed++; $display("FAIL full_refuse5: got count=%0d rdy=%b expected 4 0", count, ld_ready);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (!(count === 3'd3 && ld_ready === 1'b1 && vec_out === 3'b001 && vec_strobe === 1'b1)) begin
      tests_failed++;
      $display("FAIL full_first_pop: got count=%0d rdy=%b vec=%b stb=%b expected 3 1 001 1", count, ld_ready, vec_out, vec_strobe);
    end
    got.push_back(vec_out);
    tick();
    ld_valid = 1'b0;
    tests_run++;
    if (!(count === 3'd4 && ld_ready === 1'b0)) begin
      tests_failed++; $display("FAIL full_accept5: got count=%0d rdy=%b expected 4 0", count, ld_ready);
    end
    for (int c = 0; c < 40 && done !== 1'b1; c++) begin
      tick();
      if (vec_strobe === 1'b1) got.push_back(vec_out);
    end
    tests_run++;
    if (done !== 1'b1 || got.size() != 5) begin
      tests_failed++; $display("FAIL full_drain: got done=%b strobes=%0d expected 1 5", done, got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (got[i] !== exp_order[i]) begin
          tests_failed++; $display("FAIL full_order%0d: got %b expected %b", i, got[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_empty_start();
    int strobes;
    do_reset();
    pulse_start();
    tests_run++;
    if (!(done === 1'b1 && busy === 1'b0 && vec_out === 3'b000)) begin
      tests_failed++; $display("FAIL empty_start: got done=%b busy=%b vec=%b expected 1 0 000", done, busy, vec_out);
    end
    strobes = (vec_strobe === 1'b1) ? 1 : 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (vec_strobe !== 1'b0) strobes++;
    end
    tests_run++;
    if (!(strobes == 0 && done === 1'b1 && vec_out === 3'b000)) begin
      tests_failed++; $display("FAIL empty_hold: got strobes=%0d done=%b vec=%b expected 0 1 000", strobes, done, vec_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [5];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b011; seq[3] = 3'b100; seq[4] = 3'b101;
    load(seq[0], 4'd1);
    load(seq[1], 4'd1);
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      tests_run++;
      if (vec_out !== seq[k/2] || vec_strobe !== ((k % 2) == 0) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d: got vec=%b stb=%b busy=%b expected vec=%b stb=%b busy=1", k, vec_out, vec_strobe, busy, seq[k/2], (k % 2) == 0);
      end
      ld_valid = 1'b0;
      start    = 1'b0;
      if (k == 0 || k == 2 || k == 4) begin
        ld_valid = 1'b1;
        ld_vec   = seq[k/2 + 2];
        ld_hold  = 4'd1;
      end
      if (k == 3) start = 1'b1;
      tick();
    end
    ld_valid = 1'b0;
    start    = 1'b0;
    tests_run++;
    if (!(done === 1'b1 && busy === 1'b0 && vec_out === 3'b101 && count === 3'd0)) begin
      tests_failed++; $display("FAIL b2b_done: got done=%b busy=%b vec=%b count=%0d expected 1 0 101 0", done, busy, vec_out, count);
    end
  endtask

  task automatic test_single_cycle();
    load(3'b111, 4'd0);
    load(3'b111, 4'd0);
    pulse_start();
    tests_run++;
    if (!(vec_out === 3'b111 && vec_strobe === 1'b1 && done === 1'b0)) begin
      tests_failed++; $display("FAIL single_c0: got vec=%b stb=%b done=%b expected 111 1 0", vec_out, vec_strobe, done);
    end
    tick();
    tests_run++;
    if (!(vec_out === 3'b111 && vec_strobe === 1'b1 && busy === 1'b1)) begin
      tests_failed++; $display("FAIL single_c1: got vec=%b stb=%b busy=%b expected 111 1 1", vec_out, vec_strobe, busy);
    end
    tick();
    tests_run++;
    if (!(done === 1'b1 && vec_strobe === 1'b0 && vec_out === 3'b111)) begin
      tests_failed++; $display("FAIL single_done: got done=%b stb=%b vec=%b expected 1 0 111", done, vec_strobe, vec_out);
    end
    load(3'b010, 4'd0);
    pulse_start();
    tests_run++;
    if (!(done === 1'b0 && vec_out === 3'b010 && vec_strobe === 1'b1)) begin
      tests_failed++; $display("FAIL restart_c0: got done=%b vec=%b stb=%b expected 0 010 1", done, vec_out, vec_strobe);
    end
    tick();
    tests_run++;
    if (!(done === 1'b1 && vec_out === 3'b010)) begin
      tests_failed++; $display("FAIL restart_done: got done=%b vec=%b expected 1 010", done, vec_out);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_sequence();
    test_full();
    test_empty_start();
    test_back_to_back();
    test_single_cycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
